// File: rtl/chan_responder_pkg.sv
// Shared widths, message codes, FSM encoding and slot layout for the channel responder.
package chan_responder_pkg;

    localparam int unsigned CPU_MSG_SIZE = 8;
    localparam int unsigned ADDR_SIZE    = 16;
    localparam int unsigned DATA_SIZE    = 32;
    localparam int unsigned TMO_W        = 8;

    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_SET        = 8'h21;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_GET        = 8'h22;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_THREAD_ADDRESS  = 8'h23;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_RES_WR     = 8'h24;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_RES_RD     = 8'h25;
    localparam logic [CPU_MSG_SIZE-1:0] CPU_R_CHAN_NO_RESULTS = 8'h26;

    typedef enum logic [1:0] {
        StIdle,
        StThrd,
        StLook,
        StReply
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic                 full;
        logic [ADDR_SIZE-1:0] chan_addr;
        logic [DATA_SIZE-1:0] data;
        logic [ADDR_SIZE-1:0] wr_thread;
    } slot_t;

    function automatic logic [7:0] sat_add8(logic [7:0] a, logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/chan_slot_table.sv
// Mailbox slot storage with parallel channel lookup, lowest-index hit and free-slot select.
module chan_slot_table
    import chan_responder_pkg::*;
#(
    parameter int unsigned NCHAN = 4,
    parameter int unsigned IDX_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ADDR_SIZE-1:0] lookup_addr_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  slot_t                wr_slot_i,
    output logic                 hit_o,
    output logic [IDX_W-1:0]     hit_idx_o,
    output slot_t                hit_slot_o,
    output logic                 free_o,
    output logic [IDX_W-1:0]     free_idx_o
);

    slot_t slots_q [NCHAN];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCHAN; i++) begin
                slots_q[i] <= '0;
            end
        end else if (we_i) begin
            slots_q[wr_idx_i] <= wr_slot_i;
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_o      = 1'b0;
        hit_idx_o  = '0;
        free_o     = 1'b0;
        free_idx_o = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (slots_q[i].valid && (slots_q[i].chan_addr == lookup_addr_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
            if (!slots_q[i].valid) begin
                free_o     = 1'b1;
                free_idx_o = IDX_W'(i);
            end
        end
    end

    assign hit_slot_o = slots_q[hit_idx_o];

endmodule

// File: rtl/chan_responder.sv
// Dispatcher-side channel responder: takes SET/GET + thread-address beats, answers with one reply.
module chan_responder
    import chan_responder_pkg::*;
#(
    parameter int unsigned NCHAN   = 4,
    parameter int unsigned TMO_CYC = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_oe,
    input  logic                    is_bus_busy,
    input  logic [CPU_MSG_SIZE-1:0] cpu_msg_in,
    input  logic [ADDR_SIZE-1:0]    addr_in,
    input  logic [DATA_SIZE-1:0]    data_in,
    input  logic                    chan_msg_strb_i,
    output logic [CPU_MSG_SIZE-1:0] cpu_msg_out,
    output logic [ADDR_SIZE-1:0]    addr_out,
    output logic [DATA_SIZE-1:0]    data_out,
    output logic                    cpu_msg_pulse,
    output logic                    resp_busy,
    output logic [7:0]              drop_cnt
);

    localparam int unsigned IDX_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    state_e                  state_q;
    logic                    op_set_q;
    logic [ADDR_SIZE-1:0]    chan_q;
    logic [DATA_SIZE-1:0]    wdata_q;
    logic [ADDR_SIZE-1:0]    thr_q;
    logic [TMO_W-1:0]        tmo_q;
    logic [CPU_MSG_SIZE-1:0] rcode_q;
    logic [DATA_SIZE-1:0]    rdata_q;
    logic [7:0]              drop_q;

    logic beat, is_req, thr_beat, tmo_done;
    assign beat     = clk_oe & chan_msg_strb_i;
    assign is_req   = (cpu_msg_in == CPU_R_CHAN_SET) || (cpu_msg_in == CPU_R_CHAN_GET);
    assign thr_beat = beat && (cpu_msg_in == CPU_R_THREAD_ADDRESS);
    assign tmo_done = (tmo_q == TMO_W'(TMO_CYC));

    logic             hit, free;
    logic [IDX_W-1:0] hit_idx, free_idx;
    slot_t            hit_slot;

    logic                    look_we, look_drop, tbl_we;
    logic [IDX_W-1:0]        tbl_idx;
    slot_t                   tbl_wslot;
    logic [CPU_MSG_SIZE-1:0] look_code;
    logic [DATA_SIZE-1:0]    look_data;
    logic [1:0]              drop_inc;

    chan_slot_table #(
        .NCHAN (NCHAN),
        .IDX_W (IDX_W)
    ) u_table (
        .clk_i         (clk),
        .rst_ni        (rst),
        .lookup_addr_i (chan_q),
        .we_i          (tbl_we),
        .wr_idx_i      (tbl_idx),
        .wr_slot_i     (tbl_wslot),
        .hit_o         (hit),
        .hit_idx_o     (hit_idx),
        .hit_slot_o    (hit_slot),
        .free_o        (free),
        .free_idx_o    (free_idx)
    );

    always_comb begin
        look_we   = 1'b0;
        look_drop = 1'b0;
        tbl_idx   = hit_idx;
        tbl_wslot = hit_slot;
        look_code = CPU_R_CHAN_NO_RESULTS;
        look_data = '0;
        if (op_set_q) begin
            if (hit) begin
                if (!hit_slot.full) begin
                    look_we             = 1'b1;
                    tbl_wslot.full      = 1'b1;
                    tbl_wslot.data      = wdata_q;
                    tbl_wslot.wr_thread = thr_q;
                    look_code           = CPU_R_CHAN_RES_WR;
                end
            end else if (free) begin
                look_we   = 1'b1;
                tbl_idx   = free_idx;
                tbl_wslot = '{valid: 1'b1, full: 1'b1, chan_addr: chan_q,
                              data: wdata_q, wr_thread: thr_q};
                look_code = CPU_R_CHAN_RES_WR;
            end else begin
                look_drop = 1'b1;
            end
        end else if (hit && hit_slot.full) begin
            look_we        = 1'b1;
            tbl_wslot.full = 1'b0;
            look_code      = CPU_R_CHAN_RES_RD;
            look_data      = hit_slot.data;
        end
    end

    // The table commits in LOOK, so a reply stalled by the bus never loses the update.
    assign tbl_we = look_we && (state_q == StLook) && clk_oe;

    always_comb begin
        drop_inc = 2'd0;
        unique case (state_q)
            StIdle:  drop_inc = 2'd0;
            StThrd:  drop_inc = {1'b0, !thr_beat && (tmo_done || (beat && is_req))};
            StLook:  drop_inc = {1'b0, look_drop} + {1'b0, beat};
            StReply: drop_inc = {1'b0, beat};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_set_q <= 1'b0;
            chan_q   <= '0;
            wdata_q  <= '0;
            thr_q    <= '0;
            tmo_q    <= '0;
            rcode_q  <= '0;
            rdata_q  <= '0;
            drop_q   <= '0;
        end else if (clk_oe) begin
            drop_q <= sat_add8(drop_q, drop_inc);
            unique case (state_q)
                StIdle: begin
                    if (beat && is_req) begin
                        op_set_q <= (cpu_msg_in == CPU_R_CHAN_SET);
                        chan_q   <= addr_in;
                        wdata_q  <= data_in;
                        tmo_q    <= '0;
                        state_q  <= StThrd;
                    end
                end
                StThrd: begin
                    if (thr_beat) begin
                        thr_q   <= addr_in;
                        state_q <= StLook;
                    end else if (tmo_done) begin
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StLook: begin
                    rcode_q <= look_code;
                    rdata_q <= look_data;
                    state_q <= StReply;
                end
                StReply: begin
                    if (!is_bus_busy) begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign cpu_msg_pulse = clk_oe && (state_q == StReply) && !is_bus_busy;
    assign cpu_msg_out   = cpu_msg_pulse ? rcode_q : '0;
    assign addr_out      = cpu_msg_pulse ? chan_q : '0;
    assign data_out      = cpu_msg_pulse ? rdata_q : '0;
    assign resp_busy     = (state_q != StIdle);
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_chan_responder.sv
// Bench for chan_responder: directed scenarios plus random requests against a mailbox model.
module tb_chan_responder;
    import chan_responder_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clk_oe = 1'b1;
    logic                    oe_toggle;
    logic                    is_bus_busy;
    logic [CPU_MSG_SIZE-1:0] cpu_msg_in;
    logic [ADDR_SIZE-1:0]    addr_in;
    logic [DATA_SIZE-1:0]    data_in;
    logic                    chan_msg_strb_i;
    logic [CPU_MSG_SIZE-1:0] cpu_msg_out;
    logic [ADDR_SIZE-1:0]    addr_out;
    logic [DATA_SIZE-1:0]    data_out;
    logic                    cpu_msg_pulse;
    logic                    resp_busy;
    logic [7:0]              drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Mailbox model: a set of at most 4 channels, each either holding a word or empty.
    bit                   m_valid [4];
    bit                   m_full  [4];
    logic [ADDR_SIZE-1:0] m_chan  [4];
    logic [DATA_SIZE-1:0] m_data  [4];
    int                   m_drop;

    chan_responder #(
        .NCHAN   (4),
        .TMO_CYC (15)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_oe          (clk_oe),
        .is_bus_busy     (is_bus_busy),
        .cpu_msg_in      (cpu_msg_in),
        .addr_in         (addr_in),
        .data_in         (data_in),
        .chan_msg_strb_i (chan_msg_strb_i),
        .cpu_msg_out     (cpu_msg_out),
        .addr_out        (addr_out),
        .data_out        (data_out),
        .cpu_msg_pulse   (cpu_msg_pulse),
        .resp_busy       (resp_busy),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) clk_oe <= oe_toggle ? ~clk_oe : 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_full[i]  = 0;
        end
        m_drop = 0;
    endtask

    task automatic model_req(input bit is_set, input logic [ADDR_SIZE-1:0] ch,
                             input logic [DATA_SIZE-1:0] d,
                             output logic [CPU_MSG_SIZE-1:0] code,
                             output logic [DATA_SIZE-1:0] rd);
        int hit = -1;
        int fr  = -1;
        for (int i = 0; i < 4; i++) begin
            if (hit < 0 && m_valid[i] && m_chan[i] == ch) hit = i;
            if (fr < 0 && !m_valid[i]) fr = i;
        end
        code = CPU_R_CHAN_NO_RESULTS;
        rd   = '0;
        if (is_set) begin
            if (hit >= 0) begin
                if (!m_full[hit]) begin
                    m_full[hit] = 1;
                    m_data[hit] = d;
                    code        = CPU_R_CHAN_RES_WR;
                end
            end else if (fr >= 0) begin
                m_valid[fr] = 1;
                m_full[fr]  = 1;
                m_chan[fr]  = ch;
                m_data[fr]  = d;
                code        = CPU_R_CHAN_RES_WR;
            end else begin
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            end
        end else if (hit >= 0 && m_full[hit]) begin
            rd          = m_data[hit];
            m_full[hit] = 0;
            code        = CPU_R_CHAN_RES_RD;
        end
    endtask

    // Holds the beat until an enabled edge has sampled it.
    task automatic send_beat(input logic [CPU_MSG_SIZE-1:0] code,
                             input logic [ADDR_SIZE-1:0] a, input logic [DATA_SIZE-1:0] d);
        bit en = 0;
        cpu_msg_in      = code;
        addr_in         = a;
        data_in         = d;
        chan_msg_strb_i = 1'b1;
        for (int k = 0; k < 8 && !en; k++) begin
            @(negedge clk);
            en = clk_oe;
            @(posedge clk);
            #1;
        end
        chan_msg_strb_i = 1'b0;
        cpu_msg_in      = '0;
        addr_in         = '0;
        data_in         = '0;
    endtask

    // Bus is held busy for raw cycles 1..rel-1 after the thread beat.
    task automatic wait_reply(input string tag, input int rel,
                              input logic [CPU_MSG_SIZE-1:0] ec,
                              input logic [ADDR_SIZE-1:0] ea,
                              input logic [DATA_SIZE-1:0] ed, input int exp_raw);
        bit                      seen = 0;
        int                      raw  = 0;
        logic [CPU_MSG_SIZE-1:0] oc   = '0;
        logic [ADDR_SIZE-1:0]    oa   = '0;
        logic [DATA_SIZE-1:0]    od   = '0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            is_bus_busy = (k < rel);
            @(negedge clk);
            if (cpu_msg_pulse) begin
                seen = 1;
                raw  = k;
                oc   = cpu_msg_out;
                oa   = addr_out;
                od   = data_out;
            end
            @(posedge clk);
            #1;
        end
        is_bus_busy = 1'b0;
        check({tag, "_latency"}, raw, exp_raw);
        check({tag, "_code"}, oc, ec);
        check({tag, "_addr"}, oa, ea);
        check({tag, "_data"}, od, ed);
        @(negedge clk);
        check({tag, "_width"}, cpu_msg_pulse, 1'b0);
        check({tag, "_idle"}, resp_busy, 1'b0);
        check({tag, "_drop"}, drop_cnt, m_drop);
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input string tag, input bit is_set, input logic [ADDR_SIZE-1:0] ch,
                          input logic [DATA_SIZE-1:0] d, input int rel, input int exp_raw);
        logic [CPU_MSG_SIZE-1:0] ec;
        logic [DATA_SIZE-1:0]    ed;
        model_req(is_set, ch, d, ec, ed);
        send_beat(is_set ? CPU_R_CHAN_SET : CPU_R_CHAN_GET, ch, d);
        send_beat(CPU_R_THREAD_ADDRESS, 16'h0100, '0);
        wait_reply(tag, rel, ec, ch, ed, exp_raw);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        bit seen;
        rst             = 1'b0;
        oe_toggle       = 1'b0;
        is_bus_busy     = 1'b0;
        cpu_msg_in      = '0;
        addr_in         = '0;
        data_in         = '0;
        chan_msg_strb_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        @(negedge clk);
        check("rst_pulse", cpu_msg_pulse, 1'b0);
        check("rst_code", cpu_msg_out, '0);
        check("rst_addr", addr_out, '0);
        check("rst_data", data_out, '0);
        check("rst_busy", resp_busy, 1'b0);
        check("rst_drop", drop_cnt, '0);
        @(posedge clk);
        #1;

        do_req("set40", 1, 16'h0040, 32'h0000_1234, 0, 2);
        do_req("get40", 0, 16'h0040, 32'h0, 0, 2);
        do_req("get40_empty", 0, 16'h0040, 32'h0, 0, 2);

        do_req("set40_a", 1, 16'h0040, 32'hAAAA_0001, 0, 2);
        do_req("set40_b_full", 1, 16'h0040, 32'hBBBB_0002, 0, 2);
        do_req("get40_first", 0, 16'h0040, 32'h0, 0, 2);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_req($sformatf("fill%0d", i), 1, 16'h0050 + 16'(i), 32'h5000 + 32'(i), 0, 2);
        end
        check("fill_drop", drop_cnt, 8'd1);
        do_req("get_unknown", 0, 16'h0099, 32'h0, 0, 2);

        // SET with no thread beat: abandoned after the timeout, no reply.
        send_beat(CPU_R_CHAN_SET, 16'h0060, 32'hDEAD_BEEF);
        seen = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (cpu_msg_pulse) seen = 1;
            if (i == 16) check("tmo_busy_last", resp_busy, 1'b1);
            @(posedge clk);
            #1;
        end
        m_drop++;
        @(negedge clk);
        check("tmo_no_pulse", seen, 1'b0);
        check("tmo_idle", resp_busy, 1'b0);
        check("tmo_drop", drop_cnt, m_drop);
        @(posedge clk);
        #1;

        do_req("busy_set60", 1, 16'h0060, 32'h6060_6060, 7, 7);

        oe_toggle = 1'b1;
        do_req("oe_get60", 0, 16'h0060, 32'h0, 0, 4);
        oe_toggle = 1'b0;

        // Reset while the reply is stalled in REPLY.
        do_req("pre_set60", 1, 16'h0060, 32'h1111_2222, 0, 2);
        send_beat(CPU_R_CHAN_SET, 16'h0070, 32'hCAFE_F00D);
        is_bus_busy = 1'b1;
        send_beat(CPU_R_THREAD_ADDRESS, 16'h0200, '0);
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stall_busy", resp_busy, 1'b1);
        check("stall_no_pulse", cpu_msg_pulse, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst         = 1'b1;
        is_bus_busy = 1'b0;
        model_reset();
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_msg_pulse || cpu_msg_out != '0) seen = 1;
            @(posedge clk);
            #1;
        end
        check("abort_no_pulse", seen, 1'b0);
        check("abort_idle", resp_busy, 1'b0);
        do_req("abort_get70", 0, 16'h0070, 32'h0, 0, 2);
        do_req("abort_get60", 0, 16'h0060, 32'h0, 0, 2);

        for (int i = 0; i < 40; i++) begin
            int rel;
            rel = $urandom_range(0, 4);
            do_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                   16'h0040 + 16'($urandom_range(0, 5)), $urandom, rel, (rel > 2) ? rel : 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_responder.md
Name: chan_responder

Overview:
- Dispatcher-side end of the channel message protocol: receives CPU_R_CHAN_SET / CPU_R_CHAN_GET request beats, each followed by a CPU_R_THREAD_ADDRESS beat.
- Holds a small associative table of one-word channel mailboxes.
- Answers each request with exactly one reply beat: CPU_R_CHAN_RES_WR, CPU_R_CHAN_RES_RD or CPU_R_CHAN_NO_RESULTS.
- Sits on the inter-CPU message bus next to the dispatcher and serves all CPU channel controllers.

Parameters:
NCHAN, 4, number of mailbox slots (1..16).
TMO_CYC, 15, enabled cycles to wait for the thread-address beat before the request is abandoned.

Ports:
clk  in  1  system clock, all state on posedge.
rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
clk_oe  in  1  clock-enable qualifier; state advances only when clk_oe==1.
is_bus_busy  in  1  bus held by another agent; a pending reply stalls while 1.
cpu_msg_in  in  CPU_MSG_SIZE  incoming message code.
addr_in  in  ADDR_SIZE  channel address (request beat) or thread address (thread beat).
data_in  in  DATA_SIZE  write data on a SET beat.
chan_msg_strb_i  in  1  beat valid; a beat is sampled when clk_oe & chan_msg_strb_i.
cpu_msg_out  out  CPU_MSG_SIZE  reply code; 0 when cpu_msg_pulse==0.
addr_out  out  ADDR_SIZE  reply channel address; 0 when no pulse.
data_out  out  DATA_SIZE  reply data; 0 when no pulse.
cpu_msg_pulse  out  1  reply beat valid, exactly one enabled cycle per reply.
resp_busy  out  1  request in progress (any state except IDLE).
drop_cnt  out  8  saturating count of requests dropped or timed out.

Behaviour:
- Reset (rst==0 on posedge, regardless of clk_oe):
  - all slot valid/full bits cleared; state IDLE.
  - cpu_msg_pulse, cpu_msg_out, addr_out, data_out, resp_busy and drop_cnt all 0.
- Slot: {valid, full, chan_addr[ADDR], data[DATA], wr_thread[ADDR]}.
- FSM, evaluated only when clk_oe==1:
  - IDLE:
    - a sampled beat with code SET or GET latches op, chan_addr=addr_in and data_in, clears tmo_cnt, then goes to THRD.
    - any other code is ignored.
  - THRD:
    - a sampled beat with code THREAD_ADDRESS latches thr_addr=addr_in, then goes to LOOK.
    - a SET/GET beat here counts as a drop (drop_cnt++); the FSM stays in THRD.
    - tmo_cnt increments each enabled cycle; when tmo_cnt==TMO_CYC, drop_cnt++ and return to IDLE with no reply.
  - LOOK (one enabled cycle): parallel compare of chan_addr against all valid slots.
    - Hit: the lowest-index matching slot is used.
    - Miss: the lowest-index invalid slot becomes the free slot.
    - Decision:
      - SET, hit, not full: store data and wr_thread=thr_addr, set full; reply RES_WR.
      - SET, hit, full: reply NO_RESULTS; slot unchanged.
      - SET, miss, free slot exists: allocate the slot (valid=1, full=1, store data); reply RES_WR.
      - SET, miss, table full: reply NO_RESULTS; drop_cnt++.
      - GET, hit, full: reply RES_RD with data_out=slot data; clear full, keep valid.
      - GET, hit, empty, or GET miss: reply NO_RESULTS.
  - REPLY:
    - while is_bus_busy==1: hold, outputs stay 0.
    - otherwise assert cpu_msg_pulse for one enabled cycle with addr_out=chan_addr and the decided code/data (data_out=0 unless RES_RD), then go to IDLE.
- Latency: reply pulse appears 2 enabled cycles after the thread beat when the bus is free.
- Beats arriving in LOOK or REPLY are dropped (drop_cnt++). Requestors retry after NO_RESULTS.
- Table updates commit in LOOK, so a stalled REPLY never loses data.
- drop_cnt saturates at 255.
- Reset mid-operation aborts without a reply; outputs are 0 the next cycle.
- When clk_oe==0: no state change; cpu_msg_pulse forced 0.

Decomposition:
- Message codes come from inter_cpu_msgs.v; widths from sizes.v.
- FSM state encodings and TMO width go in a shared chan_pkg include, alongside states.v.
- One sub-module: chan_slot_table, holding slot storage and the combinational lookup/priority-allocate logic, with a single write port driven from LOOK.

Test Plan:
- SET ch 0x40 data 0x1234, thread 0x100; then GET ch 0x40 -> RES_WR, then RES_RD with addr_out 0x40, data_out 0x1234; a second GET -> NO_RESULTS.
- Two SETs to ch 0x40 without a GET -> second reply NO_RESULTS; a following GET returns the first data.
- SET to 5 distinct channels with NCHAN=4 -> fifth reply NO_RESULTS, drop_cnt=1; GET of an unknown channel -> NO_RESULTS.
- SET beat with no thread beat for 16 enabled cycles -> no reply, drop_cnt increments, resp_busy returns to 0.
- is_bus_busy held high 5 cycles in REPLY -> pulse delayed exactly until release, width 1; also verify clk_oe toggling halves throughput.
- rst=0 while in REPLY -> no pulse, the table is empty afterwards, and GET -> NO_RESULTS.
